// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one read outstanding on the
// instruction bus and hands (pc, instr) to IF/ID through a one-entry buffer.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_REQ      | read for pc is (or is about to be) on the bus
//   S_IDLE     | output buffer full, waiting for it to be consumed
//   S_DISCARD  | stale read still on the bus after a redirect; drop its data
module fetch_stage #(
  parameter int                XLEN     = 64,
  parameter int                ILEN     = 32,
  parameter logic [XLEN-1:0]   PC_RESET = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_IDLE    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            out_valid_d;
  logic [XLEN-1:0] out_pc_d;
  logic [ILEN-1:0] out_instr_d;
  logic            ireq_valid_d;
  logic [XLEN-1:0] ireq_addr_d;
  logic            data_ok;
  logic            consume;
  logic            req_held;

  // The first cycle after reset sits in S_REQ with nothing on the bus yet,
  // so a response only counts while a request is actually presented.
  assign data_ok  = iresp_data_ok & ireq_valid;
  assign consume  = out_valid & ~stall;
  assign req_held = ireq_valid & ~data_ok;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid;
    out_pc_d    = out_pc;
    out_instr_d = out_instr;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (redirect) begin
      out_valid_d = 1'b0;
      pc_d        = redirect_pc;
      state_d     = req_held ? S_DISCARD : S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (data_ok) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = iresp_data;
            pc_d        = pc_q + XLEN'(4);
            state_d     = S_IDLE;
          end
        end
        S_IDLE: begin
          if (consume || !out_valid) begin
            state_d = S_REQ;
          end
        end
        S_DISCARD: begin
          if (data_ok) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    // A request already on the bus keeps its address until its response.
    ireq_valid_d = (state_d == S_REQ) || (state_d == S_DISCARD);
    ireq_addr_d  = req_held ? ireq_addr : pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= PC_RESET;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      ireq_valid <= 1'b0;
      ireq_addr  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_valid  <= out_valid_d;
      out_pc     <= out_pc_d;
      out_instr  <= out_instr_d;
      ireq_valid <= ireq_valid_d;
      ireq_addr  <= ireq_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency bus responder, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_fetch_stage;

  localparam logic [63:0] PC_RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int age = 0;
  bit started = 1'b0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return ~a[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus memory: answers a presented request after `lat` cycles.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      age = 0;
      iresp_data_ok = 1'b0;
    end else begin
      if (iresp_data_ok) age = 0;
      iresp_data_ok = 1'b0;
      if (ireq_valid) begin
        age++;
        if (age >= lat) begin
          iresp_data_ok = 1'b1;
          iresp_data = mem(ireq_addr);
        end
      end
    end
  end

  // Reference model: one outstanding read, a possibly stale flag, next pc, buffer.
  logic        m_active, m_stale, m_ov;
  logic [63:0] m_addr, m_pc, m_opc;
  logic [31:0] m_oin;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_stale  <= 1'b0;
      m_addr   <= '0;
      m_pc     <= PC_RST;
      m_ov     <= 1'b0;
      m_opc    <= '0;
      m_oin    <= '0;
    end else begin
      if (m_ov && !stall) m_ov <= 1'b0;
      if (redirect) begin
        m_ov <= 1'b0;
        m_pc <= redirect_pc;
        if (m_active && !iresp_data_ok) begin
          m_stale <= 1'b1;
        end else begin
          m_active <= 1'b1;
          m_addr   <= redirect_pc;
          m_stale  <= 1'b0;
        end
      end else if (m_active) begin
        if (iresp_data_ok) begin
          if (m_stale) begin
            m_addr  <= m_pc;
            m_stale <= 1'b0;
          end else begin
            m_active <= 1'b0;
            m_ov     <= 1'b1;
            m_opc    <= m_addr;
            m_oin    <= mem(m_addr);
            m_pc     <= m_addr + 64'd4;
          end
        end
      end else if (!m_ov || !stall) begin
        m_active <= 1'b1;
        m_addr   <= m_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ireq_valid", {63'd0, ireq_valid}, {63'd0, m_active});
      if (m_active) check("ireq_addr", ireq_addr, m_addr);
      check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      check("out_pc", out_pc, m_opc);
      check("out_instr", {32'd0, out_instr}, {32'd0, m_oin});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ov(input string tag);
    int i = 0;
    while (!out_valid && i < 60) begin cyc(1); i++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s out_valid timeout actual=0 expected=1", tag);
    end
  endtask

  task automatic wait_fresh(input string tag);
    int i = 0;
    while (!(ireq_valid && !iresp_data_ok && age == 1) && i < 60) begin cyc(1); i++; end
    checks++;
    if (!(ireq_valid && !iresp_data_ok && age == 1)) begin
      errors++;
      $display("FAIL %s fresh request timeout actual=0 expected=1", tag);
    end
  endtask

  task automatic wait_ok(input string tag);
    int i = 0;
    while (!iresp_data_ok && i < 60) begin cyc(1); i++; end
    checks++;
    if (!iresp_data_ok) begin
      errors++;
      $display("FAIL %s data_ok timeout actual=0 expected=1", tag);
    end
  endtask

  initial begin
    cyc(3);
    started = 1'b1;
    check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b1;
    cyc(1);
    check("first_req_valid", {63'd0, ireq_valid}, 64'd1);
    check("first_req_addr", ireq_addr, 64'h8000_0000);

    // 1-cycle bus, free running
    wait_ov("t1");
    check("t1_out_pc", out_pc, 64'h8000_0000);
    check("t1_out_instr", {32'd0, out_instr}, 64'h7FFF_FFFF);
    cyc(8);

    // stall with full buffer
    wait_ov("t2");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t2_stall_noreq", {63'd0, ireq_valid}, 64'd0);
    end
    stall = 1'b0;
    cyc(4);

    // 3-cycle bus latency
    lat = 3;
    cyc(12);

    // redirect while a request is outstanding
    wait_fresh("t4");
    redirect = 1'b1;
    redirect_pc = 64'h8000_0100;
    cyc(1);
    redirect = 1'b0;
    wait_ov("t4");
    check("t4_out_pc", out_pc, 64'h8000_0100);
    check("t4_out_instr", {32'd0, out_instr}, 64'h7FFF_FEFF);
    cyc(3);

    // redirect in the same cycle as data_ok
    lat = 2;
    wait_ok("t5a");
    redirect = 1'b1;
    redirect_pc = 64'h8000_0200;
    cyc(1);
    redirect = 1'b0;
    wait_ov("t5a");
    check("t5a_out_pc", out_pc, 64'h8000_0200);
    check("t5a_out_instr", {32'd0, out_instr}, 64'h7FFF_FDFF);
    cyc(3);

    // back-to-back redirects while discarding
    lat = 4;
    wait_fresh("t5b");
    redirect = 1'b1;
    redirect_pc = 64'h8000_0300;
    cyc(1);
    redirect_pc = 64'h8000_0400;
    cyc(1);
    redirect = 1'b0;
    wait_ov("t5b");
    check("t5b_out_pc", out_pc, 64'h8000_0400);
    check("t5b_out_instr", {32'd0, out_instr}, 64'h7FFF_FBFF);
    cyc(3);

    // reset with a full buffer, then reset mid-request
    lat = 3;
    stall = 1'b1;
    wait_ov("t6a");
    reset = 1'b0;
    #1;
    check("t6a_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6a_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    cyc(2);
    stall = 1'b0;
    reset = 1'b1;
    cyc(1);
    check("t6a_restart_addr", ireq_addr, 64'h8000_0000);
    wait_fresh("t6b");
    reset = 1'b0;
    #1;
    check("t6b_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6b_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("t6b_restart_addr", ireq_addr, 64'h8000_0000);
    wait_ov("t6b");
    check("t6b_out_pc", out_pc, 64'h8000_0000);
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
